// File: rtl/water_inlet_arbiter.sv
// water_inlet_arbiter: shares one inlet valve between N washing-machine controllers.
// Round-robin grant, fixed fill window, then a closed-valve pressure-recovery gap.
module water_inlet_arbiter #(
    parameter int N           = 4,
    parameter int FILL_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] abort,
    output logic [N-1:0] grant,
    output logic         valve_open,
    output logic [N-1:0] fill_done,
    output logic [N-1:0] fill_abort,
    output logic [7:0]   fill_count
);

    localparam int MAXC = (FILL_CYCLES > GAP_CYCLES) ? FILL_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] FILL_LOAD = CW'(FILL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        GAP
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   done_q, done_d;
    logic [N-1:0]   abort_q, abort_d;
    logic [7:0]     count_q, count_d;

    logic [N-1:0]   eligible;
    logic [N-1:0]   rotated;
    logic           found;
    int             offset;
    int             selInt;
    int             nextInt;
    logic [N-1:0]   selOneHot;
    logic [PW-1:0]  nextPtr;
    logic           doArb;
    logic           ownerAbort;

    assign eligible = req & ~abort;

    // Rotate so bit 0 is the pointer position; the first set bit is the winner.
    always_comb begin
        rotated = N'({eligible, eligible} >> ptr_q);
        found   = 1'b0;
        offset  = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        selInt = int'(ptr_q) + offset;
        if (selInt >= N) begin
            selInt = selInt - N;
        end
        nextInt = selInt + 1;
        if (nextInt >= N) begin
            nextInt = 0;
        end
        selOneHot = {{(N-1){1'b0}}, 1'b1} << PW'(selInt);
        nextPtr   = PW'(nextInt);
    end

    assign doArb      = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0));
    assign ownerAbort = |(grant_q & (~req | abort));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        abort_d = '0;
        count_d = count_q;

        if (doArb) begin
            if (found) begin
                state_d = FILL;
                grant_d = selOneHot;
                cnt_d   = FILL_LOAD;
                ptr_d   = nextPtr;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    // An abort on the final fill cycle still counts as an abort.
                    if (ownerAbort) begin
                        state_d = GAP;
                        grant_d = '0;
                        abort_d = grant_q;
                        cnt_d   = GAP_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = GAP;
                        grant_d = '0;
                        done_d  = grant_q;
                        count_d = count_q + 8'd1;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    cnt_d = cnt_q - 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            abort_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            count_q <= count_d;
        end
    end

    // Valve drive comes only from registered grant, so inputs cannot glitch it.
    assign grant      = grant_q;
    assign valve_open = |grant_q;
    assign fill_done  = done_q;
    assign fill_abort = abort_q;
    assign fill_count = count_q;

endmodule
